// File: rtl/pio_bank_debounced.sv
// Avalon-MM PIO bank: debounced, edge-captured inputs with maskable IRQ,
// plus an output register with atomic set/clear aliases.
module pio_bank_debounced #(
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned OUT_WIDTH       = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 0,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_chipselect,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  input  logic [3:0]           avs_byteenable,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out,
  output logic                 irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
  logic [IN_WIDTH-1:0]  stable_q, stable_d_q, stable_n;
  logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
  logic [CNT_W-1:0]     cnt_n [IN_WIDTH];
  logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_n;
  logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_n;
  logic [IN_WIDTH-1:0]  edge_hit_c;
  logic [OUT_WIDTH-1:0] out_q, out_n;
  logic [31:0]          be_mask_c, wdata_m_c, rdata_c;
  logic [31:0]          readdata_q;
  logic                 irq_q;
  logic                 wr_c;
  logic                 unused_bits;

  assign be_mask_c = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                      {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
  assign wdata_m_c = avs_writedata & be_mask_c;
  assign wr_c      = avs_chipselect & avs_write;
  assign unused_bits = ^{wdata_m_c, be_mask_c};

  // Debounce: counter runs only while synced differs from stable.
  always_comb begin
    stable_n = stable_q;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      cnt_n[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_n[i] = sync2_q[i];
        end else begin
          cnt_n[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge qualification against the previous stable value.
  always_comb begin
    edge_hit_c = '0;
    case (EDGE_MODE)
      0:       edge_hit_c = stable_q & ~stable_d_q;
      1:       edge_hit_c = ~stable_q & stable_d_q;
      default: edge_hit_c = stable_q ^ stable_d_q;
    endcase
  end

  // Register writes; a new edge wins over a same-cycle W1C.
  always_comb begin
    out_n      = out_q;
    irq_mask_n = irq_mask_q;
    edge_cap_n = edge_cap_q;
    if (wr_c) begin
      case (avs_address)
        ADDR_DATA_OUT: out_n = (out_q & ~be_mask_c[OUT_WIDTH-1:0])
                             | wdata_m_c[OUT_WIDTH-1:0];
        ADDR_OUT_SET:  out_n = out_q | wdata_m_c[OUT_WIDTH-1:0];
        ADDR_OUT_CLR:  out_n = out_q & ~wdata_m_c[OUT_WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_n = (irq_mask_q & ~be_mask_c[IN_WIDTH-1:0])
                                  | wdata_m_c[IN_WIDTH-1:0];
        ADDR_EDGE_CAP: edge_cap_n = edge_cap_q & ~wdata_m_c[IN_WIDTH-1:0];
        default: ;
      endcase
    end
    edge_cap_n = edge_cap_n | edge_hit_c;
  end

  always_comb begin
    rdata_c = '0;
    case (avs_address)
      ADDR_DATA_IN:  rdata_c = 32'(stable_q);
      ADDR_DATA_OUT: rdata_c = 32'(out_q);
      ADDR_IRQ_MASK: rdata_c = 32'(irq_mask_q);
      ADDR_EDGE_CAP: rdata_c = 32'(edge_cap_q);
      default:       rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      stable_d_q <= '0;
      for (int i = 0; i < int'(IN_WIDTH); i++) cnt_q[i] <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      out_q      <= OUT_RESET;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= pio_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_n;
      stable_d_q <= stable_q;
      for (int i = 0; i < int'(IN_WIDTH); i++) cnt_q[i] <= cnt_n[i];
      irq_mask_q <= irq_mask_n;
      edge_cap_q <= edge_cap_n;
      out_q      <= out_n;
      if (avs_chipselect && avs_read) readdata_q <= rdata_c;
      irq_q      <= |(edge_cap_q & irq_mask_q);
    end
  end

  assign avs_readdata = readdata_q;
  assign pio_out      = out_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pio_bank_debounced.sv
// Directed bench for pio_bank_debounced; expected values go through a scoreboard queue.
module tb_pio_bank_debounced;

  localparam int unsigned IW = 32;
  localparam int unsigned OW = 6;
  localparam int unsigned DC = 8;

  localparam logic [2:0] A_DIN  = 3'd0;
  localparam logic [2:0] A_DOUT = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_ECAP = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;
  localparam logic [2:0] A_RSV  = 3'd6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    address;
  logic          chipselect, read, write;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;
  logic [IW-1:0] pio_in;
  logic [OW-1:0] pio_out;
  logic          irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  pio_bank_debounced #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0), .OUT_RESET('0)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(address), .avs_chipselect(chipselect), .avs_read(read),
    .avs_write(write), .avs_writedata(writedata), .avs_byteenable(byteenable),
    .avs_readdata(readdata), .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0x%08h expected <none>", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; chipselect = 1'b1; write = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input string tag, input logic [31:0] exp);
    expect_val(tag, exp);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read = 1'b0;
    check_pop(readdata);
  endtask

  task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    check_pop(obs);
  endtask

  initial begin
    rst_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; pio_in = '0;
    #12;
    check_now("rst_pio_out", 32'(pio_out), 32'h0);
    check_now("rst_irq", 32'(irq), 32'h0);
    check_now("rst_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    bus_read(A_DIN,  "rst_data_in", 32'h0);
    bus_read(A_DOUT, "rst_data_out", 32'h0);
    bus_read(A_MASK, "rst_irq_mask", 32'h0);
    bus_read(A_ECAP, "rst_edge_cap", 32'h0);

    // Glitch on ch0 shorter than the debounce window
    pio_in[0] = 1'b1;
    tick(DC - 2);
    pio_in[0] = 1'b0;
    tick(DC + 4);
    bus_read(A_DIN,  "glitch_data_in", 32'h0);
    bus_read(A_ECAP, "glitch_edge_cap", 32'h0);
    check_now("glitch_irq", 32'(irq), 32'h0);

    // Press on ch1 with exact latency
    bus_write(A_MASK, 32'h2, 4'hF);
    pio_in[1] = 1'b1;
    tick(DC);
    bus_read(A_DIN, "press_early1", 32'h0);
    bus_read(A_DIN, "press_early2", 32'h0);
    bus_read(A_DIN, "press_data_in", 32'h2);
    check_now("press_irq_not_yet", 32'(irq), 32'h0);
    tick(1);
    check_now("press_irq", 32'(irq), 32'h1);
    bus_read(A_ECAP, "press_edge_cap", 32'h2);

    // Release (falling edge ignored), then re-press with a coincident W1C
    pio_in[1] = 1'b0;
    tick(DC + 4);
    bus_read(A_DIN,  "release_data_in", 32'h0);
    bus_read(A_ECAP, "release_edge_cap", 32'h2);
    pio_in[1] = 1'b1;
    tick(DC + 2);
    bus_write(A_ECAP, 32'h2, 4'hF);
    bus_read(A_ECAP, "race_edge_cap", 32'h2);
    check_now("race_irq", 32'(irq), 32'h1);
    bus_write(A_ECAP, 32'h2, 4'hF);
    bus_read(A_ECAP, "w1c_edge_cap", 32'h0);
    check_now("w1c_irq", 32'(irq), 32'h0);

    // Output register and aliases
    bus_write(A_DOUT, 32'h15, 4'hF);
    check_now("dout_write", 32'(pio_out), 32'h15);
    bus_write(A_SET, 32'h0A, 4'hF);
    check_now("out_set", 32'(pio_out), 32'h1F);
    bus_write(A_CLR, 32'h03, 4'hF);
    check_now("out_clr", 32'(pio_out), 32'h1C);
    bus_read(A_SET, "out_set_reads0", 32'h0);
    bus_read(A_CLR, "out_clr_reads0", 32'h0);
    bus_write(A_DOUT, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_DOUT, "dout_width", 32'h3F);
    bus_write(A_RSV, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_RSV, "reserved", 32'h0);
    bus_write(A_CLR, 32'h3F, 4'b1110);
    check_now("clr_be_gated", 32'(pio_out), 32'h3F);

    // Byte-lane gating of IRQ_MASK
    bus_write(A_MASK, 32'h0, 4'hF);
    bus_write(A_MASK, 32'hAABB_CCDD, 4'b0101);
    bus_read(A_MASK, "mask_byteenable", 32'h00BB_00DD);

    // Asynchronous reset in the middle of a debounce on ch2
    bus_write(A_DOUT, 32'h2A, 4'hF);
    pio_in = 32'h4;
    tick(DC / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst_pio_out", 32'(pio_out), 32'h0);
    check_now("async_rst_readdata", readdata, 32'h0);
    check_now("async_rst_irq", 32'(irq), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(DC);
    bus_read(A_DIN, "rst_restart_early1", 32'h0);
    bus_read(A_DIN, "rst_restart_early2", 32'h0);
    bus_read(A_DIN, "rst_restart_data_in", 32'h4);
    bus_read(A_MASK, "rst_mask_cleared", 32'h0);
    bus_read(A_ECAP, "rst_restart_edge_cap", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
